harq_send_reader: RTL and testbench

Read-out engine on the far side of the combine buffers. On a send request it streams every combined soft-bit word of one code block from the selected ping or pong combine buffer to the HARQ/decoder interface. Each 16-lane, 10-bit-per-lane word is saturated to 8 bits per lane on the way out. The output uses a valid/ready handshake with full backpressure, and the block signals completion back to the combine FSM so the buffer can be reused.

---
 rtl/harq_send_reader.sv | 152 +++++++++++++++
 tb/tb_harq_send_reader.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/harq_send_reader.sv
// Streams one code block of combined soft bits from the ping or pong buffer to the
// HARQ/decoder interface, saturating each lane from IN_W to OUT_W bits.
module harq_send_reader #(
  parameter int unsigned LANES      = 16,
  parameter int unsigned IN_W       = 10,
  parameter int unsigned OUT_W      = 8,
  parameter int unsigned ADDR_WIDTH = 11
) (
  input  logic                    i_core_clk,
  input  logic                    i_rx_rst,
  input  logic                    i_SENDHARQ_Data_request,
  input  logic                    i_SENDHARQ_Data_PingPong_Indicator,
  input  logic [15:0]             i_SENDHARQ_Data_ncb,
  output logic                    o_SENDHARQ_Busy,
  output logic                    o_COMB_Read_En,
  output logic                    o_COMB_Read_Select,
  output logic [ADDR_WIDTH-1:0]   o_COMB_Read_Address,
  input  logic [LANES*IN_W-1:0]   i_COMB_Ping_Read_Data,
  input  logic [LANES*IN_W-1:0]   i_COMB_Pong_Read_Data,
  output logic                    o_HARQ_Data_Valid,
  output logic [LANES*OUT_W-1:0]  o_HARQ_Data,
  output logic                    o_HARQ_Data_Last,
  input  logic                    i_HARQ_Data_Ready,
  output logic [ADDR_WIDTH-1:0]   o_SENDHARQ_Data_Address,
  output logic                    o_SENDHARQ_Data_Comp
);

  localparam int unsigned IN_WORD  = LANES * IN_W;
  localparam int unsigned OUT_WORD = LANES * OUT_W;
  localparam int unsigned WORDS_W  = 12;
  localparam logic [WORDS_W-1:0] MAX_LAST = WORDS_W'((1 << ADDR_WIDTH) - 1);
  localparam logic signed [IN_W-1:0] SAT_HI = IN_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [IN_W-1:0] SAT_LO = -SAT_HI;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, COMPLETE} state_t;

  state_t                  state, state_nxt;
  logic                    sel_q, q_sel, q_vld;
  logic [ADDR_WIDTH-1:0]   last_q, addr_q, q_addr, last_c;
  logic [WORDS_W-1:0]      ncb_words;
  logic [1:0]              count;
  logic [2:0]              credit;
  logic                    wr_ptr, rd_ptr, pop, issue, start;
  logic [OUT_WORD-1:0]     fifo_data [2];
  logic [ADDR_WIDTH-1:0]   fifo_addr [2];
  logic                    fifo_last [2];
  logic [IN_WORD-1:0]      q_word;
  logic [OUT_WORD-1:0]     sat_word;
  logic signed [IN_W-1:0]  lane;
  logic                    unused_ncb_lsb;

  assign unused_ncb_lsb = ^i_SENDHARQ_Data_ncb[3:0];
  assign ncb_words      = i_SENDHARQ_Data_ncb[15:4];
  assign last_c         = (ncb_words > MAX_LAST) ? ADDR_WIDTH'(MAX_LAST) : ADDR_WIDTH'(ncb_words);
  assign start          = (state == IDLE) && i_SENDHARQ_Data_request;

  assign o_HARQ_Data_Valid       = (count != 2'd0);
  assign o_HARQ_Data             = fifo_data[rd_ptr];
  assign o_HARQ_Data_Last        = fifo_last[rd_ptr];
  assign o_SENDHARQ_Data_Address = fifo_addr[rd_ptr];
  assign o_SENDHARQ_Busy         = (state != IDLE);
  assign o_SENDHARQ_Data_Comp    = (state == COMPLETE);
  assign o_COMB_Read_Select      = sel_q;
  assign o_COMB_Read_Address     = addr_q;
  // Read strobe looks at this cycle's pop so a full pipe keeps streaming without bubbles.
  assign o_COMB_Read_En          = issue;

  assign pop    = o_HARQ_Data_Valid & i_HARQ_Data_Ready;
  assign credit = 3'(count) + 3'(q_vld);

  always_ff @(posedge i_core_clk) begin
    if (i_rx_rst) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE:     if (i_SENDHARQ_Data_request) state_nxt = READ;
      READ: begin
        issue = (credit < 3'd2) || ((credit == 3'd2) && pop);
        if (issue && (addr_q == last_q)) state_nxt = DRAIN;
      end
      DRAIN:    if (pop && o_HARQ_Data_Last) state_nxt = COMPLETE;
      COMPLETE: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Request latch, read address counter and read-latency pipeline.
  always_ff @(posedge i_core_clk) begin
    if (i_rx_rst) begin
      sel_q  <= 1'b0;
      last_q <= '0;
      addr_q <= '0;
      q_vld  <= 1'b0;
      q_sel  <= 1'b0;
      q_addr <= '0;
    end else begin
      q_vld <= issue;
      if (issue) begin
        q_sel  <= sel_q;
        q_addr <= addr_q;
      end
      if (start) begin
        sel_q  <= i_SENDHARQ_Data_PingPong_Indicator;
        last_q <= last_c;
        addr_q <= '0;
      end else if (issue && (addr_q != last_q)) begin
        addr_q <= addr_q + ADDR_WIDTH'(1);
      end
    end
  end

  // Symmetric per-lane clamp of the selected buffer word.
  always_comb begin
    q_word   = q_sel ? i_COMB_Pong_Read_Data : i_COMB_Ping_Read_Data;
    sat_word = '0;
    lane     = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      lane = q_word[k*IN_W +: IN_W];
      if (lane > SAT_HI)      sat_word[k*OUT_W +: OUT_W] = OUT_W'(SAT_HI);
      else if (lane < SAT_LO) sat_word[k*OUT_W +: OUT_W] = OUT_W'(SAT_LO);
      else                    sat_word[k*OUT_W +: OUT_W] = OUT_W'(lane);
    end
  end

  // Two-entry first-word-fall-through output FIFO; credit gating keeps it from overflowing.
  always_ff @(posedge i_core_clk) begin
    if (i_rx_rst) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_addr[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
    end else begin
      if (q_vld) begin
        fifo_data[wr_ptr] <= sat_word;
        fifo_addr[wr_ptr] <= q_addr;
        fifo_last[wr_ptr] <= (q_addr == last_q);
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(q_vld) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_harq_send_reader.sv
// Directed bench for harq_send_reader: ping/pong buffer models with 1-cycle latency,
// per-scenario tasks with inline expected-value checks.
module tb_harq_send_reader;

  logic         clk = 1'b0, rst = 1'b1, req = 1'b0, pp = 1'b0, ready = 1'b1;
  logic [15:0]  ncb = 16'h0;
  logic         busy, rd_en, rd_sel, valid, last, comp;
  logic [10:0]  rd_addr, dat_addr;
  logic [159:0] ping_q = '0, pong_q = '0;
  logic [127:0] data;

  logic [159:0] ping_mem [0:2047];
  logic [159:0] pong_mem [0:2047];

  int n_cmp = 0, n_bad = 0;

  logic [127:0] cap_data [$];
  int           cap_addr [$];
  bit           cap_last [$];
  int           cap_cyc  [$];
  int           comp_cyc, unstable, selbad, first_rd_addr;
  bit           timeout, busy1, rden1;

  harq_send_reader dut (
    .i_core_clk                         (clk),
    .i_rx_rst                           (rst),
    .i_SENDHARQ_Data_request            (req),
    .i_SENDHARQ_Data_PingPong_Indicator (pp),
    .i_SENDHARQ_Data_ncb                (ncb),
    .o_SENDHARQ_Busy                    (busy),
    .o_COMB_Read_En                     (rd_en),
    .o_COMB_Read_Select                 (rd_sel),
    .o_COMB_Read_Address                (rd_addr),
    .i_COMB_Ping_Read_Data              (ping_q),
    .i_COMB_Pong_Read_Data              (pong_q),
    .o_HARQ_Data_Valid                  (valid),
    .o_HARQ_Data                        (data),
    .o_HARQ_Data_Last                   (last),
    .i_HARQ_Data_Ready                  (ready),
    .o_SENDHARQ_Data_Address            (dat_addr),
    .o_SENDHARQ_Data_Comp               (comp)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en) begin
      ping_q <= ping_mem[rd_addr];
      pong_q <= pong_mem[rd_addr];
    end
  end

  function automatic logic [127:0] exp_word(input logic sel, input int a);
    logic [159:0]      w;
    logic signed [9:0] v;
    logic [127:0]      r;
    w = sel ? pong_mem[a] : ping_mem[a];
    r = '0;
    for (int k = 0; k < 16; k++) begin
      v = w[10*k +: 10];
      if (v > 10'sd127)       r[8*k +: 8] = 8'h7f;
      else if (v < -10'sd127) r[8*k +: 8] = 8'h81;
      else                    r[8*k +: 8] = v[7:0];
    end
    return r;
  endfunction

  function automatic int bad_words(input logic sel, input int lst);
    int b = 0;
    for (int i = 0; i < cap_data.size(); i++)
      if (cap_data[i] !== exp_word(sel, i) || cap_addr[i] != i || cap_last[i] != (i == lst)) b++;
    return b;
  endfunction

  // Issues one request and records every handshake until Comp or the cycle limit.
  task automatic run_block(input logic sel, input logic [15:0] n, input int mode,
                           input int limit, input int inj);
    int           cyc;
    logic [140:0] prev;
    bit           stalled;
    cap_data.delete(); cap_addr.delete(); cap_last.delete(); cap_cyc.delete();
    comp_cyc = -1; unstable = 0; selbad = 0; timeout = 0; first_rd_addr = -1;
    stalled = 0; prev = '0; busy1 = 0; rden1 = 0;
    @(posedge clk); #1;
    req = 1'b1; pp = sel; ncb = n; ready = 1'b1;
    cyc = 0;
    while (comp_cyc < 0 && !timeout) begin
      @(posedge clk); #1;
      cyc++;
      req = (cyc == inj);
      pp  = ~sel;
      ncb = (cyc == inj) ? 16'h0FF0 : 16'h0010;
      if (mode == 0)                  ready = 1'b1;
      else if (cyc >= 20 && cyc < 30) ready = 1'b0;
      else                            ready = 1'($urandom_range(0, 1));
      #1;
      if (cyc == 1) begin busy1 = busy; rden1 = rd_en; end
      if (rd_en && rd_sel !== sel) selbad++;
      if (rd_en && first_rd_addr < 0) first_rd_addr = int'(rd_addr);
      if (stalled && {valid, last, dat_addr, data} !== prev) unstable++;
      stalled = valid && !ready;
      prev    = {valid, last, dat_addr, data};
      if (valid && ready) begin
        cap_data.push_back(data); cap_addr.push_back(int'(dat_addr));
        cap_last.push_back(last); cap_cyc.push_back(cyc);
      end
      if (comp) comp_cyc = cyc;
      if (cyc >= limit) timeout = 1;
    end
    req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, rd_en, rd_sel, rd_addr, valid, data, last, dat_addr, comp} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got valid=%b busy=%b rd_en=%b comp=%b data=%h", valid, busy, rd_en, comp, data);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({busy, rd_en, valid, comp} !== 4'b0) begin
      n_bad++; $display("FAIL reset_release_idle: got busy=%b rd_en=%b valid=%b comp=%b want 0", busy, rd_en, valid, comp);
    end
  endtask

  task automatic test_basic_ping();
    int c0, c4;
    run_block(1'b0, 16'd64, 0, 100, -1);
    c0 = (cap_cyc.size() > 0) ? cap_cyc[0] : -1;
    c4 = (cap_cyc.size() > 4) ? cap_cyc[4] : -1;
    n_cmp++;
    if ({busy1, rden1} !== 2'b11 || first_rd_addr != 0) begin
      n_bad++; $display("FAIL basic_first_read: got busy=%b rd_en=%b addr=%0d want 1 1 0", busy1, rden1, first_rd_addr);
    end
    n_cmp++;
    if (cap_data.size() != 5) begin n_bad++; $display("FAIL basic_count: got %0d want 5", cap_data.size()); end
    n_cmp++;
    if (c0 != 3 || c4 != 7) begin n_bad++; $display("FAIL basic_timing: got first=%0d last=%0d want 3 7", c0, c4); end
    n_cmp++;
    if (bad_words(1'b0, 4) != 0) begin n_bad++; $display("FAIL basic_words: got %0d bad words want 0", bad_words(1'b0, 4)); end
    n_cmp++;
    if (cap_data.size() < 5 || cap_data[4] !== {16{8'h04}}) begin
      n_bad++; $display("FAIL basic_word4: got %h want %h", (cap_data.size() > 4) ? cap_data[4] : '0, {16{8'h04}});
    end
    n_cmp++;
    if (comp_cyc != 8) begin n_bad++; $display("FAIL basic_comp: got cycle %0d want 8", comp_cyc); end
    n_cmp++;
    if (selbad != 0) begin n_bad++; $display("FAIL basic_pong_select: got %0d pong reads want 0", selbad); end
    @(posedge clk); #1;
    n_cmp++;
    if ({busy, comp} !== 2'b00) begin n_bad++; $display("FAIL basic_idle_after: got busy=%b comp=%b want 0 0", busy, comp); end
  endtask

  task automatic test_saturation();
    run_block(1'b1, 16'h0000, 0, 50, -1);
    n_cmp++;
    if (cap_data.size() != 1 || cap_data[0] !== {64'h0, 8'h7e, 8'h81, 8'h7f, 8'h00, 8'h81, 8'h7f, 8'h81, 8'h7f}) begin
      n_bad++; $display("FAIL sat_lanes: got n=%0d data=%h want %h", cap_data.size(),
                        (cap_data.size() > 0) ? cap_data[0] : '0, {64'h0, 64'h7e817f00817f817f});
    end
  endtask

  task automatic test_boundaries();
    run_block(1'b0, 16'd8, 0, 50, -1);
    n_cmp++;
    if (cap_data.size() != 1 || !cap_last[0] || cap_addr[0] != 0) begin
      n_bad++; $display("FAIL ncb8_single: got n=%0d want 1 word with Last", cap_data.size());
    end
    n_cmp++;
    if (comp_cyc != 4) begin n_bad++; $display("FAIL ncb8_comp: got cycle %0d want 4", comp_cyc); end
    run_block(1'b1, 16'hFFFF, 0, 2200, -1);
    n_cmp++;
    if (cap_data.size() != 2048) begin n_bad++; $display("FAIL ncbmax_count: got %0d want 2048", cap_data.size()); end
    n_cmp++;
    if (bad_words(1'b1, 2047) != 0) begin n_bad++; $display("FAIL ncbmax_words: got %0d bad want 0", bad_words(1'b1, 2047)); end
    n_cmp++;
    if (comp_cyc != 2051) begin n_bad++; $display("FAIL ncbmax_comp: got cycle %0d want 2051", comp_cyc); end
  endtask

  task automatic test_backpressure();
    run_block(1'b1, 16'd2048, 1, 2000, -1);
    n_cmp++;
    if (cap_data.size() != 129 || timeout) begin
      n_bad++; $display("FAIL bp_count: got %0d timeout=%0d want 129 0", cap_data.size(), timeout);
    end
    n_cmp++;
    if (bad_words(1'b1, 128) != 0) begin n_bad++; $display("FAIL bp_words: got %0d bad want 0", bad_words(1'b1, 128)); end
    n_cmp++;
    if (unstable != 0) begin n_bad++; $display("FAIL bp_stable: got %0d changes during stall want 0", unstable); end
  endtask

  task automatic test_busy_request();
    run_block(1'b0, 16'd64, 0, 100, 2);
    n_cmp++;
    if (cap_data.size() != 5 || bad_words(1'b0, 4) != 0) begin
      n_bad++; $display("FAIL busyreq_words: got n=%0d bad=%0d want 5 0", cap_data.size(), bad_words(1'b0, 4));
    end
    n_cmp++;
    if (comp_cyc != 8 || selbad != 0) begin
      n_bad++; $display("FAIL busyreq_comp: got comp=%0d selbad=%0d want 8 0", comp_cyc, selbad);
    end
  endtask

  task automatic test_back_to_back();
    run_block(1'b1, 16'd16, 0, 50, -1);
    run_block(1'b0, 16'd32, 0, 50, -1);
    n_cmp++;
    if (cap_cyc.size() != 3 || cap_cyc[0] != 3 || comp_cyc != 6) begin
      n_bad++; $display("FAIL b2b_second: got n=%0d first=%0d comp=%0d want 3 3 6", cap_cyc.size(),
                        (cap_cyc.size() > 0) ? cap_cyc[0] : -1, comp_cyc);
    end
    n_cmp++;
    if (bad_words(1'b0, 2) != 0) begin n_bad++; $display("FAIL b2b_words: got %0d bad want 0", bad_words(1'b0, 2)); end
  endtask

  task automatic test_reset_mid_block();
    int hs = 0, stray = 0;
    @(posedge clk); #1;
    req = 1'b1; pp = 1'b1; ncb = 16'd64; ready = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      req = 1'b0;
      #1;
      if (valid && ready) hs++;
    end
    n_cmp++;
    if (hs != 3) begin n_bad++; $display("FAIL rstmid_pre: got %0d handshakes want 3", hs); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if ({busy, rd_en, rd_sel, rd_addr, valid, data, last, dat_addr, comp} !== '0) begin
      n_bad++; $display("FAIL rstmid_outputs: got valid=%b busy=%b rd_en=%b sel=%b addr=%0d comp=%b", valid, busy, rd_en, rd_sel, rd_addr, comp);
    end
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (comp || valid || busy) stray++;
    end
    n_cmp++;
    if (stray != 0) begin n_bad++; $display("FAIL rstmid_no_comp: got %0d active cycles want 0", stray); end
    run_block(1'b0, 16'd32, 0, 50, -1);
    n_cmp++;
    if (first_rd_addr != 0 || cap_data.size() != 3 || bad_words(1'b0, 2) != 0) begin
      n_bad++; $display("FAIL rstmid_restart: got addr=%0d n=%0d want 0 3", first_rd_addr, cap_data.size());
    end
  endtask

  initial begin
    for (int a = 0; a < 2048; a++)
      for (int k = 0; k < 16; k++) begin
        ping_mem[a][10*k +: 10] = 10'(a);
        pong_mem[a][10*k +: 10] = 10'(a * 7 + k * 40);
      end
    pong_mem[0] = '0;
    pong_mem[0][9:0]   = 10'h1FF;
    pong_mem[0][19:10] = 10'h200;
    pong_mem[0][29:20] = 10'h07F;
    pong_mem[0][39:30] = 10'h380;
    pong_mem[0][49:40] = 10'h000;
    pong_mem[0][59:50] = 10'h080;
    pong_mem[0][69:60] = 10'h381;
    pong_mem[0][79:70] = 10'h07E;

    test_reset();
    test_basic_ping();
    test_saturation();
    test_boundaries();
    test_backpressure();
    test_busy_request();
    test_back_to_back();
    test_reset_mid_block();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
